// File: rtl/mem_responder.sv
// Serves 16-byte line read/write requests from a core as four 32-bit beats on a
// single-port synchronous SRAM, after a fixed MEM_LATENCY wait.
module mem_responder #(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         is_mem_req,
    input  logic         is_memory_we,
    input  logic [19:0]  mem_addr_out,
    input  logic [127:0] mem_data_out,
    input  logic         is_mem_req_reset,
    output logic [127:0] data_from_mem,
    output logic         is_mem_ready,
    output logic         sram_en,
    output logic         sram_we,
    output logic [17:0]  sram_addr,
    output logic [31:0]  sram_wdata,
    input  logic [31:0]  sram_rdata,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'((MEM_LATENCY == 0) ? 0 : MEM_LATENCY - 1);

    state_t         state_q, state_d;
    logic           armed_q, armed_d;
    logic           we_q, we_d;
    logic [15:0]    line_q, line_d;
    logic [127:0]   wdata_q, wdata_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic [2:0]     beat_q, beat_d;
    logic           ready_q, ready_d;
    logic [127:0]   data_q, data_d;
    logic           sram_en_q, sram_en_d;
    logic           sram_we_q, sram_we_d;
    logic [17:0]    sram_addr_q, sram_addr_d;
    logic [31:0]    sram_wdata_q, sram_wdata_d;
    logic           busy_q, busy_d;
    logic           rd_pend_q, rd_pend_d;
    logic [1:0]     rd_idx_q, rd_idx_d;
    logic           issue;

    logic unused_addr_bits;
    assign unused_addr_bits = ^mem_addr_out[3:0];

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        we_d         = we_q;
        line_d       = line_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        beat_d       = beat_q;
        ready_d      = 1'b0;
        data_d       = data_q;
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        issue        = 1'b0;
        // The SRAM returns read data one cycle after the strobe, so track the beat in flight.
        rd_pend_d    = sram_en_q & ~sram_we_q;
        rd_idx_d     = sram_addr_q[1:0];

        if (rd_pend_q) begin
            data_d[{rd_idx_q, 5'b0} +: 32] = sram_rdata;
        end
        if (!is_mem_req) begin
            armed_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (is_mem_req && armed_q) begin
                    armed_d    = 1'b0;
                    we_d       = is_memory_we;
                    line_d     = mem_addr_out[19:4];
                    wdata_d    = mem_data_out;
                    wait_cnt_d = 4'd0;
                    beat_d     = 3'd0;
                    if (MEM_LATENCY == 0) begin
                        state_d = XFER;
                        issue   = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = XFER;
                    wait_cnt_d = 4'd0;
                    beat_d     = 3'd0;
                    issue      = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            XFER: begin
                if (beat_q < 3'd3) begin
                    beat_d = beat_q + 3'd1;
                    issue  = 1'b1;
                end else if (beat_q == 3'd3 && !we_q) begin
                    beat_d = 3'd4;  // drain cycle for the last read beat
                end else begin
                    state_d = DONE;
                    beat_d  = 3'd0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            sram_en_d    = 1'b1;
            sram_we_d    = we_d;
            sram_addr_d  = {line_d, beat_d[1:0]};
            sram_wdata_d = wdata_d[{beat_d[1:0], 5'b0} +: 32];
        end

        if (is_mem_req_reset) begin
            state_d      = IDLE;
            armed_d      = 1'b1;
            wait_cnt_d   = 4'd0;
            beat_d       = 3'd0;
            ready_d      = 1'b0;
            sram_en_d    = 1'b0;
            sram_we_d    = 1'b0;
            sram_addr_d  = sram_addr_q;
            sram_wdata_d = sram_wdata_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            armed_q      <= 1'b1;
            we_q         <= 1'b0;
            line_q       <= '0;
            wdata_q      <= '0;
            wait_cnt_q   <= '0;
            beat_q       <= '0;
            ready_q      <= 1'b0;
            data_q       <= '0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            busy_q       <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_idx_q     <= '0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            we_q         <= we_d;
            line_q       <= line_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            beat_q       <= beat_d;
            ready_q      <= ready_d;
            data_q       <= data_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            busy_q       <= busy_d;
            rd_pend_q    <= rd_pend_d;
            rd_idx_q     <= rd_idx_d;
        end
    end

    assign data_from_mem = data_q;
    assign is_mem_ready  = ready_q;
    assign sram_en       = sram_en_q;
    assign sram_we       = sram_we_q;
    assign sram_addr     = sram_addr_q;
    assign sram_wdata    = sram_wdata_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with MEM_LATENCY=2 (index 0) and one with 0 (index 1),
// each with its own behavioural SRAM; only the selected one receives requests.
module tb_mem_responder;
    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, req, we, abort, sel;
    logic [19:0]  addr;
    logic [127:0] wdata;
    logic         req_i   [2];
    logic [127:0] dout    [2];
    logic         rdy     [2];
    logic         sen     [2];
    logic         swe     [2];
    logic [17:0]  saddr   [2];
    logic [31:0]  swdata  [2];
    logic [31:0]  srdata  [2];
    logic         busy    [2];

    logic [31:0]  mem0 [logic [17:0]];
    logic [31:0]  mem1 [logic [17:0]];
    logic [50:0]  acc_log [$];
    int           rdy_cnt = 0;
    int           n_checks = 0;
    int           n_err = 0;

    localparam logic [127:0] RD_LINE = 128'h00000044_00000033_00000022_00000011;

    assign req_i[0] = req & ~sel;
    assign req_i[1] = req & sel;

    mem_responder #(.MEM_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst_n), .is_mem_req(req_i[0]), .is_memory_we(we),
        .mem_addr_out(addr), .mem_data_out(wdata), .is_mem_req_reset(abort & ~sel),
        .data_from_mem(dout[0]), .is_mem_ready(rdy[0]), .sram_en(sen[0]), .sram_we(swe[0]),
        .sram_addr(saddr[0]), .sram_wdata(swdata[0]), .sram_rdata(srdata[0]), .busy(busy[0])
    );

    mem_responder #(.MEM_LATENCY(0)) u_dut_lat0 (
        .clk(clk), .rst(rst_n), .is_mem_req(req_i[1]), .is_memory_we(we),
        .mem_addr_out(addr), .mem_data_out(wdata), .is_mem_req_reset(abort & sel),
        .data_from_mem(dout[1]), .is_mem_ready(rdy[1]), .sram_en(sen[1]), .sram_we(swe[1]),
        .sram_addr(saddr[1]), .sram_wdata(swdata[1]), .sram_rdata(srdata[1]), .busy(busy[1])
    );

    always @(posedge clk) begin
        if (sen[0]) begin
            if (swe[0]) mem0[saddr[0]] = swdata[0];
            else srdata[0] <= mem0.exists(saddr[0]) ? mem0[saddr[0]] : 32'h0;
        end
        if (sen[1]) begin
            if (swe[1]) mem1[saddr[1]] = swdata[1];
            else srdata[1] <= mem1.exists(saddr[1]) ? mem1[saddr[1]] : 32'h0;
        end
    end

    always @(negedge clk) begin
        if (sen[sel]) acc_log.push_back({swe[sel], saddr[sel], swdata[sel]});
        if (rdy[sel]) rdy_cnt++;
    end

    function automatic logic [31:0] mem0_rd(input logic [17:0] a);
        return mem0.exists(a) ? mem0[a] : 32'h0;
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge with req low.
    task automatic do_req(input string tag, input logic w, input logic [19:0] a,
                          input logic [127:0] d, input int exp_lat, input int hold);
        int c;
        int r0;
        r0 = rdy_cnt;
        acc_log.delete();
        req = 1'b1; we = w; addr = a; wdata = d;
        c = 0;
        forever begin
            @(negedge clk);
            if (rdy[sel] || c == 40) break;
            @(posedge clk); #1;
            c++;
        end
        check_val({tag, "_latency"}, 128'(c), 128'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check_val({tag, "_held_idle"}, {busy[sel], sen[sel]}, 2'b00);
        end
        @(posedge clk); #1;
        req = 1'b0;
        check_val({tag, "_ready_pulses"}, 128'(rdy_cnt - r0), 128'd1);
    endtask

    task automatic check_log(input string tag, input logic w, input logic [17:0] base,
                             input logic [127:0] d);
        check_val({tag, "_beats"}, 128'(acc_log.size()), 128'd4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
            if (w) check_val({tag, "_access"}, acc_log[i], {1'b1, base + 18'(i), d[32*i +: 32]});
            else   check_val({tag, "_access"}, acc_log[i][50:32], {1'b0, base + 18'(i)});
        end
    endtask

    initial begin
        logic [127:0] prev;
        int r0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; abort = 1'b0; sel = 1'b0;
        addr = '0; wdata = '0;
        for (int i = 0; i < 4; i++) begin
            mem0[18'h48 + 18'(i)] = 32'h11 * (i + 1);
            mem1[18'h48 + 18'(i)] = 32'h11 * (i + 1);
        end
        #12;
        check_val("reset_ctrl", {busy[0], rdy[0], sen[0], swe[0]}, 4'b0000);
        check_val("reset_sram_bus", {saddr[0], swdata[0]}, 50'h0);
        check_val("reset_data", dout[0], 128'h0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        do_req("read_lat2", 1'b0, 20'h00120, 128'h0, 8, 0);
        check_val("read_lat2_data", dout[0], RD_LINE);
        check_log("read_lat2", 1'b0, 18'h48, 128'h0);

        @(posedge clk); #1;
        prev = dout[0];
        do_req("write_lat2", 1'b1, 20'h00FF0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 7, 0);
        check_log("write_lat2", 1'b1, 18'h3FC, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        check_val("write_lat2_mem", {mem0_rd(18'h3FF), mem0_rd(18'h3FE), mem0_rd(18'h3FD), mem0_rd(18'h3FC)},
                  128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        check_val("write_keeps_data", dout[0], prev);
        check_val("idle_holds_addr", {sen[0], saddr[0], swdata[0]}, {1'b0, 18'h3FF, 32'hDDDDDDDD});

        @(posedge clk); #1;
        sel = 1'b1;
        do_req("read_lat0", 1'b0, 20'h00120, 128'h0, 6, 3);
        check_val("read_lat0_data", dout[1], RD_LINE);
        sel = 1'b0;

        // Abort a write while beat 1 is on the bus.
        @(posedge clk); #1;
        acc_log.delete();
        r0 = rdy_cnt;
        req = 1'b1; we = 1'b1; addr = 20'h00200; wdata = 128'h44444444_33333333_22222222_11111111;
        repeat (4) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; req = 1'b0;
        @(negedge clk);
        check_val("abort_idle", {busy[0], sen[0], swe[0]}, 3'b000);
        repeat (8) @(posedge clk);
        #1;
        check_val("abort_no_ready", 128'(rdy_cnt - r0), 128'd0);
        check_val("abort_mem", {mem0_rd(18'h83), mem0_rd(18'h82), mem0_rd(18'h81), mem0_rd(18'h80)},
                  128'h00000000_00000000_22222222_11111111);
        do_req("read_after_abort", 1'b0, 20'h00120, 128'h0, 8, 0);
        check_val("read_after_abort_data", dout[0], RD_LINE);

        // Asynchronous reset while waiting.
        @(posedge clk); #1;
        r0 = rdy_cnt;
        req = 1'b1; we = 1'b0; addr = 20'h00120;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_outputs", {busy[0], rdy[0], sen[0], swe[0], saddr[0], swdata[0]}, 54'h0);
        check_val("async_rst_data", dout[0], 128'h0);
        req = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("async_rst_no_ready", 128'(rdy_cnt - r0), 128'd0);
        do_req("read_after_rst", 1'b0, 20'h00120, 128'h0, 8, 0);
        check_val("read_after_rst_data", dout[0], RD_LINE);

        // Back-to-back: one low cycle between a read and a write.
        @(posedge clk); #1;
        do_req("b2b_read", 1'b0, 20'h00120, 128'h0, 8, 0);
        @(posedge clk); #1;
        do_req("b2b_write", 1'b1, 20'h00040, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 7, 0);
        check_val("b2b_write_mem", {mem0_rd(18'h13), mem0_rd(18'h12), mem0_rd(18'h11), mem0_rd(18'h10)},
                  128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
        check_val("b2b_data_kept", dout[0], RD_LINE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: MEM_LATENCY, 2, wait cycles between request capture and first SRAM beat; legal range 0..15.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-low.
REQ-004 Port: is_mem_req  input  1  core request, level, held by core until is_mem_ready.
REQ-005 Port: is_memory_we  input  1  1 = line write, 0 = line read; sampled with the request.
REQ-006 Port: mem_addr_out  input  20  physical byte address; bits [19:4] select the 16-byte line, bits [3:0] ignored.
REQ-007 Port: mem_data_out  input  128  write line; word i = bits [32i+31:32i].
REQ-008 Port: is_mem_req_reset  input  1  abort of the outstanding request.
REQ-009 Port: data_from_mem  output  128  read line returned to core; word i = bits [32i+31:32i].
REQ-010 Port: is_mem_ready  output  1  one-cycle completion pulse.
REQ-011 Port: sram_en  output  1  SRAM access strobe.
REQ-012 Port: sram_we  output  1  SRAM write strobe, only with sram_en.
REQ-013 Port: sram_addr  output  18  SRAM word address = {line[19:4], beat[1:0]}.
REQ-014 Port: sram_wdata  output  32  SRAM write word.
REQ-015 Port: sram_rdata  input  32  SRAM read word, valid the cycle after the sram_en read cycle.
REQ-016 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, XFER, DONE.
REQ-018 IDLE -> WAIT on is_mem_req=1 while armed; SHALL capture address, we and 128-bit write data in that cycle (cycle 0); request inputs ignored thereafter until IDLE.
REQ-019 WAIT SHALL last exactly MEM_LATENCY cycles; MEM_LATENCY=0 goes IDLE -> XFER directly.
REQ-020 XFER write: 4 cycles, beat 0..3 in order, sram_en=sram_we=1, sram_wdata = captured word i.
REQ-021 XFER read: 4 issue cycles (sram_en=1, sram_we=0, beats 0..3) plus 1 drain cycle; sram_rdata of beat i stored into word i the cycle after its issue.
REQ-022 DONE: exactly one cycle, is_mem_ready=1, then IDLE.
REQ-023 Latency: is_mem_ready high in cycle MEM_LATENCY+6 for reads, MEM_LATENCY+5 for writes.
REQ-024 data_from_mem SHALL be updated only by read beats and hold its value until the next read; writes leave it unchanged.
REQ-025 Re-arm: after DONE, a new request SHALL be accepted only after is_mem_req has been sampled 0 at least once; a request held high through DONE is not re-served.
REQ-026 is_mem_req_reset=1 in any state SHALL force IDLE next cycle, no is_mem_ready, sram_en/sram_we 0 from that next cycle; already-written words stay written; wins over a simultaneous new request; re-arm flag set.
REQ-027 sram_en, sram_we SHALL be 0 outside XFER; sram_addr and sram_wdata SHALL hold their last value when idle.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, armed, beat/wait counters 0, is_mem_ready 0, data_from_mem 0, sram_en 0, sram_we 0, sram_addr 0, sram_wdata 0, busy 0.
REQ-029 Reset mid-transfer SHALL abandon the request with no completion pulse; first request after release is served normally.

Verification
REQ-030 MEM_LATENCY=2, read addr 0x00120, SRAM words 0x11,0x22,0x33,0x44 at 0x00048..0x0004B -> sram_addr 0x48..0x4B, is_mem_ready in cycle 8, data_from_mem = 0x00000044_00000033_00000022_00000011.
REQ-031 MEM_LATENCY=2, write addr 0x00FF0, data 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> sram writes 0xAAAAAAAA@0x003FC .. 0xDDDDDDDD@0x003FF, is_mem_ready in cycle 7, data_from_mem unchanged.
REQ-032 MEM_LATENCY=0 read -> is_mem_ready in cycle 6; is_mem_req held high 3 extra cycles after ready -> no second transfer, busy stays 0.
REQ-033 is_mem_req_reset pulsed in XFER of write after beat 1 -> words 0,1 written, words 2,3 not, no is_mem_ready, IDLE next cycle; new read after req low served with correct latency.
REQ-034 rst asserted in WAIT -> all outputs 0 asynchronously, busy 0; read after release completes normally.
REQ-035 Back-to-back: read, req low 1 cycle, write -> second request captured on its first high cycle, both complete with REQ-023 latencies.
